// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 key buffer: prefix byte values,
// key_data bit positions and the receiver state encoding.
// No logic; imported by ps2_rx and ps2_key_buffer.
package ps2_pkg;

  // Prefix bytes that modify the following scan code
  localparam logic [7:0] PS2_PREFIX_EXT = 8'hE0;
  localparam logic [7:0] PS2_PREFIX_BRK = 8'hF0;

  // Bit positions inside the 32-bit key_data word
  localparam int KEY_VALID_BIT = 31;
  localparam int KEY_OVF_BIT   = 30;
  localparam int KEY_EXT_BIT   = 9;
  localparam int KEY_BRK_BIT   = 8;

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    PARITY,
    STOP
  } rx_state_t;

endpackage

// File: rtl/ps2_rx.sv
// Purpose: PS/2 frame receiver (2-FF sync, falling-edge sampling, parity/stop check, timeout).
// Latency: o_byte_valid pulses for one clk, one cycle after the synchronised stop-bit edge.
// Backpressure: none; the PS/2 device cannot be stalled, so o_byte_valid must be consumed when high.
// Ports: clk, rst (sync, active-high), ps2_clk/ps2_data (raw async lines),
//        o_byte[7:0] received data, o_byte_valid one-cycle strobe.
module ps2_rx
  import ps2_pkg::*;
#(
  parameter int TIMEOUT = 50000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] o_byte,
  output logic       o_byte_valid
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT - 1);

  logic            r_clk_s1, r_clk_s2, r_clk_prev;
  logic            r_dat_s1, r_dat_s2;
  rx_state_t       r_state;
  logic [7:0]      r_shift;
  logic [2:0]      r_bitcnt;
  logic            r_par;
  logic [TW-1:0]   r_to_cnt;
  logic            w_fall;

  assign w_fall = r_clk_prev & ~r_clk_s2;

  always_ff @(posedge clk) begin
    if (rst) begin
      // Synchronisers reset to the idle-high bus level so that leaving
      // reset never looks like a falling edge.
      r_clk_s1     <= 1'b1;
      r_clk_s2     <= 1'b1;
      r_clk_prev   <= 1'b1;
      r_dat_s1     <= 1'b1;
      r_dat_s2     <= 1'b1;
      r_state      <= IDLE;
      r_shift      <= 8'd0;
      r_bitcnt     <= 3'd0;
      r_par        <= 1'b0;
      r_to_cnt     <= '0;
      o_byte       <= 8'd0;
      o_byte_valid <= 1'b0;
    end else begin
      r_clk_s1     <= ps2_clk;
      r_clk_s2     <= r_clk_s1;
      r_clk_prev   <= r_clk_s2;
      r_dat_s1     <= ps2_data;
      r_dat_s2     <= r_dat_s1;
      o_byte_valid <= 1'b0;

      if (w_fall) begin
        r_to_cnt <= '0;
        case (r_state)
          IDLE: begin
            // A sampled 1 is not a start bit; stay idle.
            if (!r_dat_s2) begin
              r_state  <= DATA;
              r_bitcnt <= 3'd0;
            end
          end
          DATA: begin
            // LSB first: shift in from the top
            r_shift  <= {r_dat_s2, r_shift[7:1]};
            r_bitcnt <= r_bitcnt + 3'd1;
            if (r_bitcnt == 3'd7) r_state <= PARITY;
          end
          PARITY: begin
            r_par   <= r_dat_s2;
            r_state <= STOP;
          end
          STOP: begin
            // Odd parity over data + parity bit, and stop bit must be 1
            if (r_dat_s2 && (^{r_shift, r_par})) begin
              o_byte       <= r_shift;
              o_byte_valid <= 1'b1;
            end
            r_state <= IDLE;
          end
          default: r_state <= IDLE;
        endcase
      end else if (r_state != IDLE) begin
        if (r_to_cnt == TO_LAST) begin
          r_state  <= IDLE;
          r_to_cnt <= '0;
        end else begin
          r_to_cnt <= r_to_cnt + TW'(1);
        end
      end else begin
        r_to_cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/ps2_key_buffer.sv
// Purpose: PS/2 key event queue behind the CPU key region; folds E0/F0 prefixes into one event.
// Latency: event visible on key_data one cycle after byte_valid; key_data is combinational from the head.
// Backpressure: none upstream; a full queue drops new events and sets the sticky overflow flag.
// Ports: clk, rst (sync, active-high), ps2_clk/ps2_data (raw PS/2 lines), read_key (pop strobe),
//        key_data[31:0] head word, key_count occupancy, overflow sticky drop flag.
module ps2_key_buffer
  import ps2_pkg::*;
#(
  parameter int DEPTH   = 8,
  parameter int TIMEOUT = 50000
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     ps2_clk,
  input  logic                     ps2_data,
  input  logic                     read_key,
  output logic [31:0]              key_data,
  output logic [$clog2(DEPTH):0]   key_count,
  output logic                     overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [7:0]    w_rx_byte;
  logic          w_rx_vld;
  logic          r_ext, r_brk;
  logic [9:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wptr, r_rptr;
  logic [CW-1:0] r_count;
  logic          r_ovf;

  logic          w_is_ext, w_is_brk, w_push, w_push_ok, w_pop;
  logic          w_empty, w_full;
  logic [9:0]    w_event;

  ps2_rx #(.TIMEOUT(TIMEOUT)) u_rx (
    .clk          (clk),
    .rst          (rst),
    .ps2_clk      (ps2_clk),
    .ps2_data     (ps2_data),
    .o_byte       (w_rx_byte),
    .o_byte_valid (w_rx_vld)
  );

  assign w_is_ext = w_rx_vld && (w_rx_byte == PS2_PREFIX_EXT);
  assign w_is_brk = w_rx_vld && (w_rx_byte == PS2_PREFIX_BRK);
  assign w_push   = w_rx_vld && !w_is_ext && !w_is_brk;
  assign w_event  = {r_ext, r_brk, w_rx_byte};

  assign w_empty  = (r_count == '0);
  assign w_full   = (r_count == CW'(DEPTH));
  // Pop on empty is ignored even when a push lands in the same cycle.
  assign w_pop    = read_key && !w_empty;
  // A full queue still accepts a push when a pop frees the head slot this cycle.
  assign w_push_ok = w_push && (!w_full || w_pop);

  always_ff @(posedge clk) begin
    if (w_push_ok) r_mem[r_wptr] <= w_event;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ext   <= 1'b0;
      r_brk   <= 1'b0;
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_ovf   <= 1'b0;
    end else begin
      if (w_is_ext) r_ext <= 1'b1;
      if (w_is_brk) r_brk <= 1'b1;
      if (w_push) begin
        // Flags are consumed by the event even if the queue drops it.
        r_ext <= 1'b0;
        r_brk <= 1'b0;
      end
      if (w_push && !w_push_ok) r_ovf <= 1'b1;
      if (w_push_ok) r_wptr <= r_wptr + AW'(1);
      if (w_pop)     r_rptr <= r_rptr + AW'(1);
      case ({w_push_ok, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_comb begin
    key_data = 32'd0;
    key_data[KEY_OVF_BIT] = r_ovf;
    if (!w_empty) begin
      key_data[KEY_VALID_BIT]  = 1'b1;
      key_data[KEY_EXT_BIT:0]  = r_mem[r_rptr];
    end
  end

  assign key_count = r_count;
  assign overflow  = r_ovf;

  // The brk bit position is implied by the event packing {ext, brk, code}.
  if (KEY_BRK_BIT != KEY_EXT_BIT - 1) begin : g_bad_layout
    $error("key_data ext/brk bit layout does not match event packing");
  end

endmodule

// File: tb/tb_ps2_key_buffer.sv
module tb_ps2_key_buffer;

  localparam int DEPTH   = 8;
  localparam int TIMEOUT = 100;
  localparam int HALF    = 6;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ps2_clk = 1'b1;
  logic        ps2_data = 1'b1;
  logic        read_key = 1'b0;
  logic [31:0] key_data;
  logic [3:0]  key_count;
  logic        overflow;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: a plain queue of {ext,brk,code} events plus flags.
  logic [9:0] mq[$];
  bit         m_ovf = 1'b0;
  bit         m_ext = 1'b0;
  bit         m_brk = 1'b0;

  ps2_key_buffer #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk       (clk),
    .rst       (rst),
    .ps2_clk   (ps2_clk),
    .ps2_data  (ps2_data),
    .read_key  (read_key),
    .key_data  (key_data),
    .key_count (key_count),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic void m_reset();
    mq.delete();
    m_ovf = 1'b0;
    m_ext = 1'b0;
    m_brk = 1'b0;
  endfunction

  function automatic void m_pop();
    if (mq.size() > 0) void'(mq.pop_front());
  endfunction

  function automatic void m_byte(input logic [7:0] b);
    if (b == 8'hE0)      m_ext = 1'b1;
    else if (b == 8'hF0) m_brk = 1'b1;
    else begin
      if (mq.size() < DEPTH) mq.push_back({m_ext, m_brk, b});
      else                   m_ovf = 1'b1;
      m_ext = 1'b0;
      m_brk = 1'b0;
    end
  endfunction

  task automatic check_state(input string tag);
    logic [31:0] exp;
    exp = 32'd0;
    exp[30] = m_ovf;
    if (mq.size() > 0) begin
      exp[31]  = 1'b1;
      exp[9:0] = mq[0];
    end
    chk({tag, ".cnt"}, 32'(key_count), 32'(mq.size()));
    chk({tag, ".dat"}, key_data, exp);
    chk({tag, ".ovf"}, 32'(overflow), 32'(m_ovf));
  endtask

  // Drive the first nbits of a frame. With pop_at_push, read_key is held for
  // exactly the cycle in which the stop-bit byte_valid is presented: the
  // falling edge needs two clk to cross the synchroniser and byte_valid is
  // registered one cycle after the edge is seen.
  task automatic send_frame(input logic [7:0] code, input bit bad_par, input bit bad_stop,
                            input int nbits, input bit pop_at_push);
    logic [10:0] fr;
    fr = {~bad_stop, (~^code) ^ bad_par, code, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      ps2_data = fr[i];
      for (int c = 0; c < HALF; c++) tick();
      ps2_clk = 1'b0;
      for (int c = 0; c < HALF; c++) begin
        tick();
        if (pop_at_push && i == 10) read_key = (c == 2);
      end
      ps2_clk = 1'b1;
    end
    read_key = 1'b0;
    ps2_data = 1'b1;
    if (pop_at_push) m_pop();
    if (nbits == 11 && !bad_par && !bad_stop) m_byte(code);
  endtask

  task automatic good(input logic [7:0] code);
    send_frame(code, 1'b0, 1'b0, 11, 1'b0);
  endtask

  task automatic rd();
    read_key = 1'b1;
    tick();
    read_key = 1'b0;
    m_pop();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    m_reset();
  endtask

  initial begin
    do_reset();
    chk("reset.cnt", 32'(key_count), 32'd0);
    chk("reset.dat", key_data, 32'd0);
    chk("reset.ovf", 32'(overflow), 32'd0);

    // Single make code
    good(8'h1C);
    chk("a.dat", key_data, 32'h8000001C);
    check_state("a");
    rd();
    chk("a_pop.dat", key_data, 32'd0);
    check_state("a_pop");

    // Extended release folds into one entry
    good(8'hE0);
    good(8'hF0);
    good(8'h75);
    chk("e0f0.dat", key_data, 32'h80000375);
    check_state("e0f0");
    rd();

    // Corrupted frames are dropped
    send_frame(8'h1C, 1'b1, 1'b0, 11, 1'b0);
    send_frame(8'h1C, 1'b0, 1'b1, 11, 1'b0);
    chk("bad.cnt", 32'(key_count), 32'd0);
    good(8'h32);
    chk("bad_then_ok.dat", key_data, 32'h80000032);
    check_state("bad_then_ok");
    rd();

    // Partial frame abandoned by timeout
    send_frame(8'h55, 1'b0, 1'b0, 6, 1'b0);
    for (int c = 0; c < TIMEOUT + 20; c++) tick();
    good(8'h1C);
    chk("timeout.dat", key_data, 32'h8000001C);
    check_state("timeout");
    rd();

    // Reset mid-frame also clears a pending prefix
    good(8'hE0);
    send_frame(8'h33, 1'b0, 1'b0, 4, 1'b0);
    do_reset();
    chk("midrst.cnt", 32'(key_count), 32'd0);
    chk("midrst.dat", key_data, 32'd0);
    good(8'h1C);
    chk("midrst_next.dat", key_data, 32'h8000001C);
    rd();

    // read_key on an empty queue has no effect
    rd();
    rd();
    check_state("empty_rd");
    good(8'h2A);
    chk("empty_rd_next.cnt", 32'(key_count), 32'd1);
    chk("empty_rd_next.dat", key_data, 32'h8000002A);
    rd();

    // Full queue with a pop in the same cycle as the push
    for (int k = 0; k < DEPTH; k++) good(8'(8'h10 + k));
    send_frame(8'h18, 1'b0, 1'b0, 11, 1'b1);
    chk("full_pp.cnt", 32'(key_count), 32'd8);
    chk("full_pp.ovf", 32'(overflow), 32'd0);
    chk("full_pp.dat", key_data, 32'h80000011);
    for (int k = 0; k < DEPTH; k++) begin
      check_state("full_pp_drain");
      rd();
    end
    check_state("full_pp_empty");

    // Overflow: DEPTH+1 codes, no reads
    for (int k = 1; k <= DEPTH + 1; k++) good(8'(k));
    chk("ovf.cnt", 32'(key_count), 32'd8);
    chk("ovf.flag", 32'(overflow), 32'd1);
    chk("ovf.dat", key_data, 32'hC0000001);
    for (int k = 1; k <= DEPTH; k++) begin
      chk("ovf_drain.dat", key_data, 32'hC0000000 | 32'(k));
      rd();
    end
    chk("ovf_empty.dat", key_data, 32'h40000000);

    // Randomised traffic against the queue model
    do_reset();
    for (int it = 0; it < 50; it++) begin
      int sel;
      logic [7:0] code;
      bit bad, pp;
      sel  = $urandom_range(0, 9);
      code = (sel == 0) ? 8'hE0 : (sel == 1) ? 8'hF0 : 8'($urandom_range(0, 255));
      bad  = ($urandom_range(0, 7) == 0);
      pp   = ($urandom_range(0, 3) == 0);
      send_frame(code, bad, 1'b0, 11, pp);
      check_state("rand");
      if ($urandom_range(0, 2) == 0) begin
        rd();
        check_state("rand_rd");
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
